// File: rtl/ufm_pkg.sv
// Shared widths and reader FSM encoding for the UFM page reader and its byte FIFO.
package ufm_pkg;

    localparam int UFM_PAGE_W     = 11;
    localparam int UFM_PAGE_BYTES = 16;
    localparam int UFM_NPAGES_W   = 12;
    localparam int UFM_BYTES_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/ufm_page_reader_if.sv
// Request, consumer byte stream and streamer-side signals of the UFM page reader.
interface ufm_page_reader_if;

    logic                              req;
    logic [ufm_pkg::UFM_PAGE_W-1:0]    req_page;
    logic [ufm_pkg::UFM_NPAGES_W-1:0]  req_npages;
    logic                              busy;
    logic                              done;
    logic                              err;

    logic [7:0]                        out_data;
    logic                              out_valid;
    logic                              out_ready;
    logic                              out_last;

    logic                              ufm_start;
    logic [ufm_pkg::UFM_PAGE_W-1:0]    ufm_page_addr;
    logic [7:0]                        ufm_data_rd;
    logic                              ufm_rd_stb;
    logic                              ufm_ready;

    // The reader side
    modport slave (
        input  req, req_page, req_npages, out_ready, ufm_data_rd, ufm_rd_stb, ufm_ready,
        output busy, done, err, out_data, out_valid, out_last, ufm_start, ufm_page_addr
    );

    // The environment side: requester, consumer and streamer
    modport master (
        output req, req_page, req_npages, out_ready, ufm_data_rd, ufm_rd_stb, ufm_ready,
        input  busy, done, err, out_data, out_valid, out_last, ufm_start, ufm_page_addr
    );

endinterface

// File: rtl/ufm_byte_fifo.sv
// Fall-through register FIFO; dout shows the head entry combinationally and reads as zero when empty.
module ufm_byte_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   free
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_C = DEPTH[AW:0];
    localparam logic [AW:0]    PTR_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      count;
    logic             push_en;
    logic             pop_en;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign free    = DEPTH_C - count;
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign dout    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/ufm_page_reader.sv
// Multi-page UFM read sequencer: requests one page at a time from ufm_streamer when the
// byte FIFO can absorb a whole page, and hands the bytes on as a valid/ready stream.
module ufm_page_reader
    import ufm_pkg::*;
#(
    parameter int PAGE_BYTES = UFM_PAGE_BYTES,
    parameter int FIFO_DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    ufm_page_reader_if.slave  bus
);

    localparam int                 FAW       = $clog2(FIFO_DEPTH);
    localparam int                 RXW       = $clog2(PAGE_BYTES);
    localparam int                 PB_M1     = PAGE_BYTES - 1;
    localparam logic [FAW:0]       PAGE_FREE = PAGE_BYTES[FAW:0];
    localparam logic [RXW-1:0]     RX_LAST   = PB_M1[RXW-1:0];
    localparam logic [RXW-1:0]     RX_ONE    = 1;

    rd_state_e                 state_q;
    logic [UFM_PAGE_W-1:0]     page_q;
    logic [UFM_PAGE_W-1:0]     ufm_page_addr_q;
    logic [UFM_NPAGES_W-1:0]   pages_left_q;
    logic [UFM_BYTES_W-1:0]    bytes_left_q;
    logic [UFM_BYTES_W-1:0]    bytes_left_d;
    logic [RXW-1:0]            rx_cnt_q;
    logic                      inflight_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      err_q;
    logic                      ufm_start_q;

    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic [FAW:0]              fifo_free;
    logic [7:0]                fifo_dout;
    logic                      page_end;
    logic                      issue;
    logic                      drained;

    // Strobes outside an in-flight page are never buffered.
    assign fifo_push    = bus.ufm_rd_stb && inflight_q;
    assign fifo_pop     = !fifo_empty && bus.out_ready;
    assign page_end     = fifo_push && (rx_cnt_q == RX_LAST);
    assign issue        = (state_q == ST_RUN) && bus.ufm_ready && !inflight_q &&
                          (pages_left_q != '0) && (fifo_free >= PAGE_FREE);
    assign bytes_left_d = (fifo_pop && (bytes_left_q != '0)) ? bytes_left_q - 16'd1 : bytes_left_q;
    assign drained      = (bytes_left_d == '0);

    ufm_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (bus.ufm_data_rd),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .free  (fifo_free)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            page_q          <= '0;
            ufm_page_addr_q <= '0;
            pages_left_q    <= '0;
            bytes_left_q    <= '0;
            rx_cnt_q        <= '0;
            inflight_q      <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            ufm_start_q     <= 1'b0;
        end else begin
            ufm_start_q  <= 1'b0;
            done_q       <= 1'b0;
            bytes_left_q <= bytes_left_d;

            if (fifo_push) begin
                rx_cnt_q <= rx_cnt_q + RX_ONE;
                if (page_end) begin
                    inflight_q   <= 1'b0;
                    pages_left_q <= pages_left_q - 12'd1;
                    page_q       <= page_q + 11'd1;
                end
            end

            if (issue) begin
                ufm_start_q     <= 1'b1;
                ufm_page_addr_q <= page_q;
                inflight_q      <= 1'b1;
                rx_cnt_q        <= '0;
            end

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.req) begin
                        page_q       <= bus.req_page;
                        pages_left_q <= bus.req_npages;
                        bytes_left_q <= UFM_BYTES_W'(bus.req_npages) * UFM_BYTES_W'(PAGE_BYTES);
                        err_q        <= 1'b0;
                        busy_q       <= 1'b1;
                        // An empty request drains through FLUSH so done lands two cycles after req.
                        state_q      <= (bus.req_npages == '0) ? ST_FLUSH : ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if ((pages_left_q == '0) && !inflight_q) begin
                        if (drained) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (drained) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // A stray or overflowing strobe outranks the clear from a same-cycle request.
            if (bus.ufm_rd_stb && (!inflight_q || fifo_full)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.err           = err_q;
    assign bus.out_data      = fifo_dout;
    assign bus.out_valid     = !fifo_empty;
    assign bus.out_last      = !fifo_empty && (bytes_left_q == 16'd1);
    assign bus.ufm_start     = ufm_start_q;
    assign bus.ufm_page_addr = ufm_page_addr_q;

endmodule

// File: tb/tb_ufm_page_reader.sv
// Directed bench for ufm_page_reader with a behavioural streamer and a byte scoreboard.
module tb_ufm_page_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ufm_page_reader_if bus ();

    ufm_page_reader #(
        .PAGE_BYTES (16),
        .FIFO_DEPTH (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks_total  = 0;
    int          checks_passed = 0;
    int          checks_failed = 0;
    int          cyc           = 0;
    int          start_cnt     = 0;
    int          pop_cnt       = 0;
    int          last_pop_cyc  = 0;
    int          start_pops[$];
    logic [7:0]  exp_q[$];
    logic [10:0] addr_q[$];
    bit          overflow_mode = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else begin
            checks_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_busy"},      32'(bus.busy),          0);
        chk({pfx, "_done"},      32'(bus.done),          0);
        chk({pfx, "_err"},       32'(bus.err),           0);
        chk({pfx, "_out_valid"}, 32'(bus.out_valid),     0);
        chk({pfx, "_out_last"},  32'(bus.out_last),      0);
        chk({pfx, "_ufm_start"}, 32'(bus.ufm_start),     0);
        chk({pfx, "_out_data"},  32'(bus.out_data),      0);
        chk({pfx, "_page_addr"}, 32'(bus.ufm_page_addr), 0);
    endtask

    // Drives req for one cycle and queues the expected page addresses and bytes.
    task automatic start_req(input logic [10:0] page, input int n);
        logic [10:0] pg;
        @(posedge clk); #1;
        bus.req        = 1'b1;
        bus.req_page   = page;
        bus.req_npages = 12'(n);
        start_cnt = 0;
        pop_cnt   = 0;
        start_pops.delete();
        for (int p = 0; p < n; p++) begin
            pg = page + 11'(p);
            addr_q.push_back(pg);
            for (int i = 0; i < 16; i++) begin
                exp_q.push_back(8'((int'(pg) * 16 + i) & 255));
            end
        end
        @(posedge clk); #1;
        bus.req = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int at);
        bit got;
        got = 1'b0;
        at  = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1;
                at  = cyc;
            end
        end
        chk({tag, "_done_seen"}, 32'(got), 1);
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk); #1;
        bus.out_ready = r;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural streamer: 16 strobes per start (17 on the 2nd page in overflow mode).
    initial begin : streamer
        logic [10:0] s_addr;
        int          s_nb;
        bus.ufm_ready   = 1'b1;
        bus.ufm_rd_stb  = 1'b0;
        bus.ufm_data_rd = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && bus.ufm_start) begin
                s_addr = bus.ufm_page_addr;
                start_cnt++;
                start_pops.push_back(pop_cnt);
                chk("start_expected", 32'(addr_q.size() != 0), 1);
                if (addr_q.size() != 0) begin
                    chk("page_addr", 32'(s_addr), 32'(addr_q.pop_front()));
                end
                s_nb = (overflow_mode && start_cnt == 2) ? 17 : 16;
                for (int i = 0; i < s_nb; i++) begin
                    @(posedge clk); #1;
                    if (!rst_n) break;
                    bus.ufm_ready   = 1'b0;
                    bus.ufm_rd_stb  = 1'b1;
                    bus.ufm_data_rd = 8'((int'(s_addr) * 16 + i) & 255);
                end
                @(posedge clk); #1;
                bus.ufm_rd_stb = 1'b0;
                bus.ufm_ready  = 1'b1;
            end
        end
    end

    // Consumer-side scoreboard: one data and one out_last comparison per accepted byte.
    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                chk("pop_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("out_data", 32'(bus.out_data), 32'(e));
                    chk("out_last", 32'(bus.out_last), 32'(exp_q.size() == 0));
                    if (exp_q.size() == 0) last_pop_cyc = cyc;
                end
                pop_cnt++;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int  at;
        bit  hit;
        bus.req        = 1'b0;
        bus.req_page   = '0;
        bus.req_npages = '0;
        bus.out_ready  = 1'b0;

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // Single page, consumer always ready
        set_ready(1'b1);
        start_req(11'h010, 1);
        wait_done("t1", 200, at);
        chk("t1_busy_at_done", 32'(bus.busy), 0);
        chk("t1_done_latency", 32'(at - last_pop_cyc), 1);
        chk("t1_starts", 32'(start_cnt), 1);
        chk("t1_pops", 32'(pop_cnt), 16);
        chk("t1_err", 32'(bus.err), 0);
        @(negedge clk);
        chk("t1_done_pulse", 32'(bus.done), 0);

        // Prefetch with backpressure: two pages buffered, third withheld
        set_ready(1'b0);
        start_req(11'h100, 3);
        repeat (80) @(negedge clk);
        chk("t2_starts_held", 32'(start_cnt), 2);
        chk("t2_valid_held", 32'(bus.out_valid), 1);
        set_ready(1'b1);
        wait_done("t2", 300, at);
        chk("t2_starts", 32'(start_cnt), 3);
        chk("t2_pops", 32'(pop_cnt), 48);
        chk("t2_third_after_16_pops", 32'(start_pops.size() >= 3 && start_pops[2] >= 16), 1);
        chk("t2_err", 32'(bus.err), 0);

        // Page address wrap 0x7FF -> 0x000
        start_req(11'h7FF, 2);
        wait_done("t3", 300, at);
        chk("t3_starts", 32'(start_cnt), 2);
        chk("t3_pops", 32'(pop_cnt), 32);

        // Zero-page request
        start_req(11'h123, 0);
        @(negedge clk);
        chk("t4_busy_c1", 32'(bus.busy), 1);
        chk("t4_done_c1", 32'(bus.done), 0);
        @(negedge clk);
        chk("t4_done_c2", 32'(bus.done), 1);
        chk("t4_busy_c2", 32'(bus.busy), 0);
        @(negedge clk);
        chk("t4_done_c3", 32'(bus.done), 0);
        chk("t4_starts", 32'(start_cnt), 0);

        // Overflow: 17 strobes on the second page while the FIFO is full
        overflow_mode = 1'b1;
        set_ready(1'b0);
        start_req(11'h200, 2);
        repeat (70) @(negedge clk);
        chk("t5_err_set", 32'(bus.err), 1);
        chk("t5_starts", 32'(start_cnt), 2);
        set_ready(1'b1);
        wait_done("t5", 300, at);
        chk("t5_pops", 32'(pop_cnt), 32);
        chk("t5_err_held", 32'(bus.err), 1);
        overflow_mode = 1'b0;

        // Reset in the middle of a 4-page read, then a normal 1-page read
        start_req(11'h300, 4);
        @(negedge clk);
        chk("t6_err_cleared", 32'(bus.err), 0);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (pop_cnt >= 5) hit = 1'b1;
        end
        chk("t6_five_bytes", 32'(hit), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        exp_q.delete();
        addr_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        start_req(11'h055, 1);
        wait_done("t6", 200, at);
        chk("t6_starts", 32'(start_cnt), 1);
        chk("t6_pops", 32'(pop_cnt), 16);
        chk("t6_err", 32'(bus.err), 0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
